// File: rtl/z_frame_buffer.sv
// rtl/z_frame_buffer.sv - frame capture for whitened samples: DIM banks, per-channel sums, held-frame reads
module z_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int SAMPLES    = 1024,
  parameter int DIM        = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          serial_z_in,
  output logic                           in_ready,
  output logic                           frame_ready,
  input  logic                           rd_en,
  input  logic [$clog2(SAMPLES)-1:0]     rd_addr,
  output logic [DIM*DATA_WIDTH-1:0]      rd_data,
  output logic                           rd_valid,
  output logic [DIM*(DATA_WIDTH+$clog2(SAMPLES))-1:0] ch_sum,
  input  logic                           frame_release,
  output logic                           overflow
);

  localparam int AW = $clog2(SAMPLES);
  localparam int SW = DATA_WIDTH + AW;
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic {LOAD, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] samp_cnt;
  logic [CW-1:0] ch_cnt;
  logic          accept;
  logic          rd_fire;

  assign in_ready    = (state == LOAD);
  assign frame_ready = (state == HOLD);
  assign accept      = in_valid && (state == LOAD);
  assign rd_fire     = rd_en && (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      samp_cnt <= '0;
      ch_cnt   <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (in_valid && (state == HOLD))
        overflow <= 1'b1;
      case (state)
        LOAD: begin
          if (in_valid) begin
            samp_cnt <= samp_cnt + AW'(1);
            // samp_cnt wraps to zero on its own, so both counters are clear on entry to HOLD
            if (samp_cnt == AW'(SAMPLES - 1)) begin
              if (ch_cnt == CW'(DIM - 1)) begin
                ch_cnt <= '0;
                state  <= HOLD;
              end else begin
                ch_cnt <= ch_cnt + CW'(1);
              end
            end
          end
        end
        HOLD: begin
          if (frame_release)
            state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  for (genvar ch = 0; ch < DIM; ch++) begin : g_bank
    logic [DATA_WIDTH-1:0] bank [SAMPLES];
    logic [DATA_WIDTH-1:0] lane_q;
    logic [SW-1:0]         acc;
    logic                  sel;

    assign sel = (ch_cnt == CW'(ch));

    // Memory has no reset: a new frame simply overwrites the old one
    always_ff @(posedge clk) begin
      if (accept && sel)
        bank[samp_cnt] <= serial_z_in;
    end

    always_ff @(posedge clk) begin
      if (!rst_n)
        lane_q <= '0;
      else if (rd_fire)
        lane_q <= bank[rd_addr];
    end

    always_ff @(posedge clk) begin
      if (!rst_n)
        acc <= '0;
      else if (accept && sel)
        acc <= acc + {{AW{serial_z_in[DATA_WIDTH-1]}}, serial_z_in};
      else if ((state == HOLD) && frame_release)
        acc <= '0;
    end

    assign rd_data[ch*DATA_WIDTH +: DATA_WIDTH] = lane_q;
    assign ch_sum[ch*SW +: SW]                  = acc;
  end

endmodule

// File: tb/tb_z_frame_buffer.sv
// tb/tb_z_frame_buffer.sv - directed table-driven bench for z_frame_buffer
module tb_z_frame_buffer;

  localparam int DW = 32;
  localparam int NS = 1024;
  localparam int ND = 5;
  localparam int AW = 10;
  localparam int SW = DW + AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     serial_z_in = '0;
  logic              in_ready;
  logic              frame_ready;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [ND*DW-1:0]  rd_data;
  logic              rd_valid;
  logic [ND*SW-1:0]  ch_sum;
  logic              frame_release = 1'b0;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int lane [ND];
  } rd_vec_t;

  rd_vec_t vecs [5];
  int      exp_sum1 [ND];

  z_frame_buffer #(.DATA_WIDTH(DW), .SAMPLES(NS), .DIM(ND)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .serial_z_in(serial_z_in),
    .in_ready(in_ready), .frame_ready(frame_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ch_sum(ch_sum),
    .frame_release(frame_release), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane_rd(input int ch);
    return longint'($signed(rd_data[ch*DW +: DW]));
  endfunction

  function automatic longint lane_sum(input int ch);
    return longint'($signed(ch_sum[ch*SW +: SW]));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams a full frame; checks frame_ready rises exactly after the final accept
  task automatic load_frame(input bit neg, input bit gaps, input string tag);
    int accepted = 0;
    int cyc = 0;
    bit early = 0;
    while (accepted < ND*NS && cyc < 30000) begin
      if (gaps && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        serial_z_in = neg ? -32'sd1 : DW'((accepted / NS) * 10000 + (accepted % NS));
      end
      if (frame_ready) early = 1;
      if (in_valid && in_ready) begin
        if (accepted == ND*NS - 1)
          check({tag, " frame_ready before last accept"}, frame_ready, 0);
        accepted++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " accepted words"}, accepted, ND*NS);
    check({tag, " early frame_ready"}, early, 0);
    check({tag, " frame_ready after last accept"}, frame_ready, 1);
    check({tag, " in_ready in HOLD"}, in_ready, 0);
  endtask

  task automatic read_check(input int addr, input int lanes [ND], input string tag);
    rd_en = 1'b1;
    rd_addr = AW'(addr);
    step();
    rd_en = 1'b0;
    check({tag, " rd_valid"}, rd_valid, 1);
    for (int ch = 0; ch < ND; ch++)
      check($sformatf("%s lane%0d", tag, ch), lane_rd(ch), lanes[ch]);
  endtask

  initial begin
    vecs[0].addr = 7;    vecs[0].lane = '{7, 10007, 20007, 30007, 40007};
    vecs[1].addr = 0;    vecs[1].lane = '{0, 10000, 20000, 30000, 40000};
    vecs[2].addr = 1023; vecs[2].lane = '{1023, 11023, 21023, 31023, 41023};
    vecs[3].addr = 512;  vecs[3].lane = '{512, 10512, 20512, 30512, 40512};
    vecs[4].addr = 100;  vecs[4].lane = '{100, 10100, 20100, 30100, 40100};
    exp_sum1 = '{523776, 10763776, 21003776, 31243776, 41483776};

    // Reset state, observed while rst_n is still low
    step();
    check("reset in_ready", in_ready, 1);
    check("reset frame_ready", frame_ready, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", lane_rd(0), 0);
    check("reset overflow", overflow, 0);
    check("reset ch_sum lane0", lane_sum(0), 0);
    rst_n = 1'b1;
    step();

    // Full gapless load, sums, then table of reads
    load_frame(1'b0, 1'b0, "load1");
    for (int ch = 0; ch < ND; ch++)
      check($sformatf("load1 ch_sum%0d", ch), lane_sum(ch), exp_sum1[ch]);
    for (int i = 0; i < 5; i++)
      read_check(vecs[i].addr, vecs[i].lane, $sformatf("vec%0d", i));
    step();
    check("idle rd_valid low", rd_valid, 0);
    check("idle rd_data held", lane_rd(4), 40100);

    // Back-to-back reads
    rd_en = 1'b1;
    rd_addr = 10'd1023;
    step();
    check("b2b0 rd_valid", rd_valid, 1);
    check("b2b0 lane0", lane_rd(0), 1023);
    rd_addr = 10'd0;
    step();
    check("b2b1 rd_valid", rd_valid, 1);
    check("b2b1 lane0", lane_rd(0), 0);
    rd_addr = 10'd512;
    step();
    check("b2b2 rd_valid", rd_valid, 1);
    check("b2b2 lane0", lane_rd(0), 512);
    rd_en = 1'b0;
    step();
    check("b2b end rd_valid", rd_valid, 0);

    // Overflow in HOLD
    in_valid = 1'b1;
    serial_z_in = 32'h7FFF_FFFF;
    step();
    in_valid = 1'b0;
    check("ovf set", overflow, 1);
    step();
    check("ovf sticky", overflow, 1);
    check("ovf frame_ready", frame_ready, 1);
    check("ovf ch_sum0", lane_sum(0), 523776);
    read_check(7, vecs[0].lane, "ovf reread");

    // Read and release on the same edge
    rd_en = 1'b1;
    rd_addr = 10'd0;
    frame_release = 1'b1;
    step();
    rd_en = 1'b0;
    frame_release = 1'b0;
    check("rel rd_valid", rd_valid, 1);
    for (int ch = 0; ch < ND; ch++)
      check($sformatf("rel lane%0d", ch), lane_rd(ch), vecs[1].lane[ch]);
    check("rel in_ready", in_ready, 1);
    check("rel frame_ready", frame_ready, 0);
    for (int ch = 0; ch < ND; ch++)
      check($sformatf("rel ch_sum%0d", ch), lane_sum(ch), 0);

    // rd_en and frame_release ignored in LOAD
    rd_en = 1'b1;
    frame_release = 1'b1;
    step();
    rd_en = 1'b0;
    frame_release = 1'b0;
    check("load rd_en ignored", rd_valid, 0);
    check("load release ignored", in_ready, 1);

    // Negative words with gaps
    load_frame(1'b1, 1'b1, "neg");
    for (int ch = 0; ch < ND; ch++)
      check($sformatf("neg ch_sum%0d", ch), lane_sum(ch), -1024);
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
    check("neg release in_ready", in_ready, 1);

    // Reset mid-frame after 3000 words
    for (int w = 0; w < 3000; w++) begin
      in_valid = 1'b1;
      serial_z_in = DW'((w / NS) * 10000 + (w % NS));
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst overflow cleared", overflow, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst ch_sum2", lane_sum(2), 0);
    load_frame(1'b0, 1'b0, "load2");
    for (int ch = 0; ch < ND; ch++)
      check($sformatf("load2 ch_sum%0d", ch), lane_sum(ch), exp_sum1[ch]);
    read_check(7, vecs[0].lane, "load2 read");

    // Reset during HOLD with a read in flight
    rd_en = 1'b1;
    rd_addr = 10'd3;
    rst_n = 1'b0;
    step();
    rd_en = 1'b0;
    rst_n = 1'b1;
    check("hold rst rd_valid", rd_valid, 0);
    check("hold rst in_ready", in_ready, 1);
    check("hold rst frame_ready", frame_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
